// File: rtl/cnn_pool_pkg.sv
// Shared pooling definitions: mode encodings and small
// elaboration/saturation helpers for the window reducer.
package cnn_pool_pkg;

  typedef enum logic [1:0] {
    POOL_MAX      = 2'b00,
    POOL_MAX_RELU = 2'b01,
    POOL_SUM      = 2'b10,
    POOL_RSVD     = 2'b11
  } pool_mode_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Node count of tree level lvl (level 0 = the window).
  function automatic int level_count(input int win, input int lvl);
    int n;
    n = win;
    for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic logic signed [63:0] sat_to_width(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // The reserved encoding behaves as plain MAX.
  function automatic pool_mode_e norm_mode(input logic [1:0] m);
    pool_mode_e r;
    unique case (m)
      2'b01:   r = POOL_MAX_RELU;
      2'b10:   r = POOL_SUM;
      default: r = POOL_MAX;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pool_reduce_lane.sv
// One channel of the pooling pipeline: window register,
// registered pairwise reduction tree and post-processing.
module pool_reduce_lane
  import cnn_pool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int WIN        = 9,
  parameter int LEVELS     = clog2(WIN)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          load,
  input  logic [WIN*DATA_WIDTH-1:0]     window,
  input  logic [2*(LEVELS+1)-1:0]       stage_mode,
  output logic [DATA_WIDTH-1:0]         result
);

  localparam int RW = DATA_WIDTH + LEVELS;
  localparam int NW = WIN + 1;
  localparam int NP = (WIN + 1) / 2;

  // Nodes are held at root width; sums can never overflow.
  logic signed [RW-1:0]         node [0:LEVELS][0:NW-1];
  logic signed [DATA_WIDTH-1:0] post_q;
  logic signed [DATA_WIDTH-1:0] out_q;
  logic signed [RW-1:0]         root;
  logic [1:0]                   root_mode;

  function automatic logic signed [RW-1:0] reduce2(
    input logic signed [RW-1:0] a,
    input logic signed [RW-1:0] b,
    input logic                 is_sum
  );
    if (is_sum) return a + b;
    return (b > a) ? b : a;
  endfunction

  assign root      = node[LEVELS][0];
  assign root_mode = stage_mode[2*LEVELS +: 2];
  assign result    = out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j <= LEVELS; j++)
        for (int i = 0; i < NW; i++)
          node[j][i] <= '0;
      post_q <= '0;
      out_q  <= '0;
    end else if (!stall) begin
      for (int i = 0; i < WIN; i++)
        if (load)
          node[0][i] <= RW'($signed(
            window[i*DATA_WIDTH +: DATA_WIDTH]));
      for (int j = 1; j <= LEVELS; j++) begin
        for (int i = 0; i < NP; i++) begin
          if (i < level_count(WIN, j)) begin
            if (2*i+1 < level_count(WIN, j-1))
              node[j][i] <= reduce2(
                node[j-1][2*i],
                node[j-1][2*i+1],
                stage_mode[2*(j-1) +: 2] == POOL_SUM);
            else
              node[j][i] <= node[j-1][2*i];
          end
        end
      end
      if (root_mode == POOL_SUM)
        post_q <= DATA_WIDTH'(sat_to_width(64'(root), DATA_WIDTH));
      else if (root_mode == POOL_MAX_RELU && root < 0)
        post_q <= '0;
      else
        post_q <= root[DATA_WIDTH-1:0];
      out_q <= post_q;
    end
  end

endmodule

// File: rtl/pool_window_reduce.sv
// Streaming K x K window pooling unit: LANES lock-step reducers
// sharing one valid/mode pipeline and a global stall.
module pool_window_reduce
  import cnn_pool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int K          = 3,
  parameter int LANES      = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [1:0]                        in_mode,
  input  logic [LANES*K*K*DATA_WIDTH-1:0]   in_window,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*DATA_WIDTH-1:0]       out_data
);

  localparam int WIN    = K * K;
  localparam int LEVELS = clog2(WIN);
  // window, tree levels, post-process, output
  localparam int NST    = LEVELS + 3;

  logic [NST-1:0]          vld;
  logic [1:0]              mode_q [0:LEVELS];
  logic [2*(LEVELS+1)-1:0] stage_mode;
  logic                    stall;

  assign out_valid = vld[NST-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  always_comb begin
    stage_mode = '0;
    for (int s = 0; s <= LEVELS; s++)
      stage_mode[2*s +: 2] = mode_q[s];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int s = 0; s <= LEVELS; s++)
        mode_q[s] <= POOL_MAX;
    end else if (!stall) begin
      vld <= {vld[NST-2:0], in_valid};
      if (in_valid)
        mode_q[0] <= norm_mode(in_mode);
      for (int s = 1; s <= LEVELS; s++)
        mode_q[s] <= mode_q[s-1];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pool_reduce_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .WIN        (WIN),
      .LEVELS     (LEVELS)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .load       (in_valid),
      .window     (in_window[l*WIN*DATA_WIDTH +: WIN*DATA_WIDTH]),
      .stage_mode (stage_mode),
      .result     (out_data[l*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_pool_window_reduce.sv
// Scoreboard bench for pool_window_reduce: directed and random
// beats against an arithmetic max/relu/saturating-sum model.
module tb_pool_window_reduce;

  localparam int DW    = 16;
  localparam int K     = 3;
  localparam int LANES = 4;
  localparam int WIN   = K * K;
  localparam int TOT   = LANES * WIN * DW;
  localparam int OW    = LANES * DW;
  localparam int LAT   = 6;

  logic           clk = 0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_mode;
  logic [TOT-1:0] in_window;
  logic           out_valid;
  logic           out_ready;
  logic [OW-1:0]  out_data;

  pool_window_reduce #(
    .DATA_WIDTH (DW),
    .K          (K),
    .LANES      (LANES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_window (in_window),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0] data;
    int            acc;
    logic          lat;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rdy_mode = 0;
  logic r_prev;
  logic [TOT-1:0] w;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [OW-1:0] model(
    input logic [TOT-1:0] win,
    input logic [1:0]     md
  );
    logic [OW-1:0]   res;
    logic signed [DW-1:0] x;
    longint s, mx, hi, lo;
    res = '0;
    hi = (64'sd1 <<< (DW - 1)) - 1;
    lo = -(64'sd1 <<< (DW - 1));
    for (int l = 0; l < LANES; l++) begin
      s  = 0;
      mx = lo - 1;
      for (int e = 0; e < WIN; e++) begin
        x = win[(l*WIN+e)*DW +: DW];
        s += x;
        if (x > mx) mx = x;
      end
      if (md == 2'b10) mx = (s > hi) ? hi : (s < lo) ? lo : s;
      else if (md == 2'b01 && mx < 0) mx = 0;
      res[l*DW +: DW] = DW'(mx);
    end
    return res;
  endfunction

  task automatic rand_win();
    for (int i = 0; i < LANES*WIN; i++)
      w[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic put(input int l, input int e, input int v);
    w[(l*WIN+e)*DW +: DW] = DW'(v);
  endtask

  task automatic drive_ready();
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((cyc / 3) % 2) == 0;
      default: out_ready = 1'($urandom % 2);
    endcase
  endtask

  task automatic send(input logic [TOT-1:0] win, input logic [1:0] md);
    exp_t ex;
    in_window = win;
    in_mode   = md;
    in_valid  = 1'b1;
    for (int t = 0; t < 300; t++) begin
      drive_ready();
      #1;
      if (in_ready) begin
        ex.data = model(win, md);
        ex.acc  = cyc + 1;
        ex.lat  = (rdy_mode == 0);
        q.push_back(ex);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      drive_ready();
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    in_valid = 1'b0;
    while (q.size() > 0 && t < 1000) begin
      drive_ready();
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
  endtask

  // Monitor: checks outputs just before each rising edge.
  initial begin
    r_prev = 1'b1;
    forever begin
      @(negedge clk);
      #2;
      if (r_prev) begin
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
          bad++;
          $display("FAIL reset_state: v=%b d=%h r=%b want 0/0/1",
                   out_valid, out_data, in_ready);
        end
      end else begin
        total++;
        if (in_ready !== !(out_valid && !out_ready)) begin
          bad++;
          $display("FAIL in_ready: got %b want %b", in_ready,
                   !(out_valid && !out_ready));
        end
        if (out_valid) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_out: got %h want none", out_data);
          end else begin
            if (out_data !== q[0].data) begin
              bad++;
              $display("FAIL data: got %h want %h", out_data, q[0].data);
            end
            if (out_ready) begin
              if (q[0].lat) begin
                total++;
                if (cyc != q[0].acc + LAT) begin
                  bad++;
                  $display("FAIL latency: got %0d want %0d",
                           cyc - q[0].acc, LAT);
                end
              end
              void'(q.pop_front());
            end
          end
        end
      end
      r_prev = reset;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: sim time exceeded want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0[9];
    a0 = '{1, -5, 7, 3, 7, 0, 2, -1, 4};
    reset     = 1'b1;
    out_ready = 1'b1;
    in_mode   = 2'b00;
    rand_win();
    in_window = w;
    in_valid  = 1'b1;
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: got %b want 1", in_ready);
    end
    @(negedge clk);

    // Directed: max, tie at saturation rail, relu, reserved, sum
    rand_win();
    for (int e = 0; e < WIN; e++) begin
      put(0, e, a0[e]);
      put(2, e, 16'h7FFF);
    end
    send(w, 2'b00);
    idle(8);
    rand_win();
    for (int e = 0; e < WIN; e++) put(1, e, -3);
    send(w, 2'b01);
    rand_win();
    send(w, 2'b11);
    rand_win();
    for (int e = 0; e < WIN; e++) begin
      put(0, e, 16'h4000);
      put(1, e, 16'hC000);
      put(2, e, e + 1);
    end
    send(w, 2'b10);
    for (int m = 0; m < 4; m++) begin
      rand_win();
      send(w, 2'(m));
    end
    drain();

    // Back-pressure with incrementing beats
    rdy_mode = 1;
    for (int b = 0; b < 10; b++) begin
      for (int l = 0; l < LANES; l++)
        for (int e = 0; e < WIN; e++)
          put(l, e, b*100 + l*10 + e - 20);
      send(w, 2'(b % 3));
    end
    drain();

    // Mid-flight reset discards everything in the pipe
    rdy_mode = 0;
    for (int b = 0; b < 4; b++) begin
      rand_win();
      send(w, 2'(b));
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    idle(10);
    rand_win();
    send(w, 2'b10);
    drain();

    // Random traffic with random back-pressure
    rdy_mode = 2;
    for (int b = 0; b < 300; b++) begin
      rand_win();
      send(w, 2'($urandom % 4));
      if ($urandom % 4 == 0) idle(1 + $urandom % 3);
    end
    drain();
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
